// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle ops pass through EXEC, shifts iterate one bit per cycle in SHIFT.
// The result is held in DONE until the consumer takes it.
module alu_seq_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         ALUcntrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [2:0]         flag,
  output logic               busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         flag_q, flag_d;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_res, sh_next;
  logic               alu_c, in_shift;

  // Borrow of a-b equals the top bit of the zero-extended difference.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
      OP_SUB: begin alu_res = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  sh_next = {a_q[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_next = {1'b0, a_q[WIDTH-1:1]};
      default: sh_next = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
    endcase
  end

  assign in_shift = (ALUcntrl == OP_SLL) || (ALUcntrl == OP_SRL) || (ALUcntrl == OP_SRA);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_d   = flag_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d  = a;
        b_d  = b;
        op_d = ALUcntrl;
        if (!in_shift) begin
          state_d = EXEC;
        end else if (b[SHAMT_W-1:0] == '0) begin
          // Zero-distance shift: the operand is the answer, skip SHIFT entirely.
          state_d  = DONE;
          result_d = a;
          flag_d   = {1'b0, a[WIDTH-1], a == '0};
        end else begin
          state_d = SHIFT;
          cnt_d   = b[SHAMT_W-1:0];
        end
      end
      EXEC: begin
        state_d  = DONE;
        result_d = alu_res;
        flag_d   = {alu_c, alu_res[WIDTH-1], alu_res == '0};
      end
      SHIFT: begin
        a_d   = sh_next;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d  = DONE;
          result_d = sh_next;
          flag_d   = {1'b0, sh_next[WIDTH-1], sh_next == '0};
        end
      end
      default: if (out_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign flag      = flag_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: expectations queued at issue, popped when out_valid appears.
`timescale 1ns/1ps
module tb_alu_seq_unit;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b, result;
  logic [3:0]  ALUcntrl;
  logic [2:0]  flag;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] last_res = '0;

  alu_seq_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUcntrl(ALUcntrl), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag(flag), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_, input logic [3:0] op);
    exp_t        e;
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    int          n;
    n = int'(tb_[4:0]);
    r = '0;
    c = 1'b0;
    e.lat = 2;
    case (op)
      4'd0: begin s = {1'b0, ta} + {1'b0, tb_}; r = s[31:0]; c = s[32]; end
      4'd1: begin r = ta - tb_; c = (ta < tb_); end
      4'd2: r = ta & tb_;
      4'd3: r = ta | tb_;
      4'd4: r = ta ^ tb_;
      4'd5: r = ~ta;
      4'd6: begin r = ta << n; e.lat = 1 + n; end
      4'd7: begin r = ta >> n; e.lat = 1 + n; end
      4'd8: begin r = $signed(ta) >>> n; e.lat = 1 + n; end
      default: r = '0;
    endcase
    e.res = r;
    e.flg = {c, r[31], r == 32'd0};
    return e;
  endfunction

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic [3:0] op);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      vec_cnt++; err_cnt++;
      $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
    end
    a = ta; b = tb_; ALUcntrl = op; in_valid = 1'b1;
    sb.push_back(model(ta, tb_, op));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ALUcntrl = 4'($urandom);
  endtask

  // Scrambles operands every cycle so latched values are the only source of truth.
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      a = $urandom; b = $urandom; ALUcntrl = 4'($urandom);
    end
  endtask

  task automatic test_reset;
    #1;
    vec_cnt += 5;
    if (in_ready !== 1'b1)   begin err_cnt++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0)  begin err_cnt++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0)       begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (result !== 32'd0)    begin err_cnt++; $display("FAIL reset_result: got %h want 0", result); end
    if (flag !== 3'b000)     begin err_cnt++; $display("FAIL reset_flag: got %b want 000", flag); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith;
    logic [31:0] va[9] = '{32'd4, 32'd3, 32'd1, 32'hFFFFFFFF, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd0, 32'd5};
    logic [31:0] vb[9] = '{32'd1, 32'd3, 32'd2, 32'd1, 32'hFF00, 32'hFF00, 32'hFF00, 32'd0, 32'd7};
    logic [3:0]  vo[9] = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15};
    int lat;
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      send(va[i], vb[i], vo[i]);
      wait_out(lat);
      e = sb.pop_front();
      vec_cnt += 4;
      if (lat != e.lat)     begin err_cnt++; $display("FAIL arith%0d_latency: got %0d want %0d", i, lat, e.lat); end
      if (result !== e.res) begin err_cnt++; $display("FAIL arith%0d_result: got %h want %h", i, result, e.res); end
      if (flag !== e.flg)   begin err_cnt++; $display("FAIL arith%0d_flag: got %b want %b", i, flag, e.flg); end
      last_res = e.res;
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
      if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL arith%0d_idle: in_ready got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_shift;
    logic [31:0] va[5] = '{32'h80000000, 32'h12345678, 32'd1, 32'h80000000, 32'hF0000001};
    logic [31:0] vb[5] = '{32'd4, 32'd0, 32'd31, 32'd31, 32'h23};
    logic [3:0]  vo[5] = '{4'd8, 4'd6, 4'd6, 4'd7, 4'd7};
    int lat;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      send(va[i], vb[i], vo[i]);
      if (sb[0].lat > 1) begin
        vec_cnt++;
        if (result !== last_res) begin err_cnt++; $display("FAIL shift%0d_hold: got %h want %h", i, result, last_res); end
      end
      wait_out(lat);
      e = sb.pop_front();
      vec_cnt += 4;
      if (lat != e.lat)     begin err_cnt++; $display("FAIL shift%0d_latency: got %0d want %0d", i, lat, e.lat); end
      if (result !== e.res) begin err_cnt++; $display("FAIL shift%0d_result: got %h want %h", i, result, e.res); end
      if (flag !== e.flg)   begin err_cnt++; $display("FAIL shift%0d_flag: got %b want %b", i, flag, e.flg); end
      last_res = e.res;
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
      if (busy !== 1'b0) begin err_cnt++; $display("FAIL shift%0d_busy: got %b want 0", i, busy); end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    exp_t e;
    send(32'd7, 32'd9, 4'd0);
    wait_out(lat);
    e = sb.pop_front();
    vec_cnt += 2;
    if (result !== e.res) begin err_cnt++; $display("FAIL bp_result: got %h want %h", result, e.res); end
    if (flag !== e.flg)   begin err_cnt++; $display("FAIL bp_flag: got %b want %b", flag, e.flg); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vec_cnt += 3;
      if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, out_valid); end
      if (result !== e.res)   begin err_cnt++; $display("FAIL bp_hold_result%0d: got %h want %h", i, result, e.res); end
      if (in_ready !== 1'b0)  begin err_cnt++; $display("FAIL bp_hold_ready%0d: got %b want 0", i, in_ready); end
    end
    last_res = e.res;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    vec_cnt += 2;
    if (in_ready !== 1'b1)  begin err_cnt++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int lat;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, 4'($urandom_range(0, 15)));
      wait_out(lat);
      e = sb.pop_front();
      vec_cnt += 4;
      if (lat != e.lat)     begin err_cnt++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, lat, e.lat); end
      if (result !== e.res) begin err_cnt++; $display("FAIL b2b%0d_result: got %h want %h", i, result, e.res); end
      if (flag !== e.flg)   begin err_cnt++; $display("FAIL b2b%0d_flag: got %b want %b", i, flag, e.flg); end
      if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL b2b%0d_done_ready: got %b want 0", i, in_ready); end
      last_res = e.res;
      @(posedge clk); #1;
      vec_cnt++;
      if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b%0d_idle: got %b want 1", i, in_ready); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_input_change;
    int lat;
    exp_t e;
    send(32'd10, 32'd20, 4'd0);
    a = 32'd0; b = 32'd0; ALUcntrl = 4'd1;
    wait_out(lat);
    e = sb.pop_front();
    vec_cnt += 2;
    if (result !== e.res) begin err_cnt++; $display("FAIL inchg_result: got %h want %h", result, e.res); end
    if (flag !== e.flg)   begin err_cnt++; $display("FAIL inchg_flag: got %b want %b", flag, e.flg); end
    last_res = e.res;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift;
    logic seen;
    send(32'h12345678, 32'd31, 4'd8);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    vec_cnt += 5;
    if (in_ready !== 1'b1)  begin err_cnt++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0)      begin err_cnt++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    if (result !== 32'd0)   begin err_cnt++; $display("FAIL rst_mid_result: got %h want 0", result); end
    if (flag !== 3'b000)    begin err_cnt++; $display("FAIL rst_mid_flag: got %b want 000", flag); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    vec_cnt += 2;
    if (seen !== 1'b0)     begin err_cnt++; $display("FAIL rst_mid_ghost_valid: got %b want 0", seen); end
    if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_mid_after_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ALUcntrl = '0;
    test_reset;
    test_arith;
    test_shift;
    test_backpressure;
    test_back_to_back;
    test_input_change;
    test_reset_mid_shift;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 32, operand/result width
- SHAMT_W, 5, shift-amount width taken from b[SHAMT_W-1:0]
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge
- rst_n, in, 1, asynchronous active-low reset
- in_valid, in, 1, request present
- in_ready, out, 1, unit can accept a request
- a, in, WIDTH, operand A
- b, in, WIDTH, operand B / shift amount
- ALUcntrl, in, 4, operation select
- out_valid, out, 1, result present
- out_ready, in, 1, consumer accepts result
- result, out, WIDTH, operation result
- flag, out, 3, {carry, sign, zero}
- busy, out, 1, high in any state other than IDLE
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE, EXEC, SHIFT, DONE; in_ready = (state==IDLE).
REQ-005 A request SHALL be accepted on a rising edge with in_valid && in_ready; a, b and ALUcntrl SHALL be latched then, and later input changes SHALL be ignored until the next acceptance.
REQ-006 Opcodes SHALL be:
- 0000 add, 0001 sub (a-b), 0010 and, 0011 or
- 0100 xor, 0101 not a, 0110 sll, 0111 srl, 1000 sra
- 1001-1111 result 0
REQ-007 For non-shift ops, IDLE SHALL go to EXEC on acceptance, then to DONE the next cycle; out_valid SHALL rise exactly 2 cycles after the accepting edge.
REQ-008 For shift ops, IDLE SHALL go to SHIFT with count = b[SHAMT_W-1:0].
- Each SHIFT cycle SHALL shift the working register 1 bit and decrement count.
- The FSM SHALL go to DONE when count reaches 0.
- Latency SHALL be 1+N cycles; N=0 SHALL go directly to DONE (latency 1).
REQ-009 Shift fill rules:
- sll: 0 shifted into LSB
- srl: 0 shifted into MSB
- sra: MSB replicated
REQ-010 Arithmetic SHALL be modulo 2^WIDTH.
- carry: carry-out for add; borrow (a<b unsigned) for sub; 0 for all other ops.
- sign = result[WIDTH-1].
- zero = (result==0).
REQ-011 In DONE, out_valid SHALL be 1 and result/flag SHALL be stable until out_valid && out_ready, then the FSM SHALL return to IDLE.
REQ-012 out_ready high on the cycle out_valid rises SHALL complete the transfer in that cycle.
REQ-013 No new request SHALL be accepted in the cycle DONE exits; the earliest acceptance SHALL be the following cycle (IDLE).
REQ-014 result and flag SHALL hold their last value in IDLE, EXEC and SHIFT until the next DONE update.

Reset
REQ-015 When rst_n is low, the following SHALL be forced immediately, in any state including mid-shift:
- state = IDLE
- result = 0, flag = 000
- out_valid = 0, busy = 0, in_ready = 1
- count = 0
REQ-016 A request or result in flight at reset SHALL be discarded; no out_valid SHALL appear after rst_n is released without a new acceptance.

Verification
REQ-017 Add: a=4, b=1, op=0000 -> out_valid 2 cycles after acceptance, result=5, flag=000.
REQ-018 Sub: a=3, b=3, op=0001 -> result=0, flag=001; then a=1, b=2, op=0001 -> result=0xFFFFFFFF, flag=110.
REQ-019 Shift: a=0x80000000, b=4, op=1000 -> busy for 5 cycles, result=0xF8000000, flag=010; b=0, op=0110 -> result=a, latency 1.
REQ-020 Backpressure: out_ready held low 10 cycles -> result/out_valid stable, in_ready=0; out_ready pulse -> IDLE next cycle.
REQ-021 Reset: rst_n low during SHIFT with b=31 -> all outputs per REQ-015 immediately; no out_valid after release.
REQ-022 Input change: a, b, op altered while busy -> result reflects the latched operands only.
